// File: rtl/pulse_pkg.sv
// Shared definitions for the square-pulse generator/receiver pair.
// Both ends derive their timing from the same nominal width.
package pulse_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int CLK_HZ    = 50_000_000;
  localparam int NOM_WIDTH = 50000;

  // Acceptance window is the nominal width +/- 20%
  localparam int DEF_MIN_WIDTH = (NOM_WIDTH * 4) / 5;
  localparam int DEF_MAX_WIDTH = (NOM_WIDTH * 6) / 5;

endpackage

// File: rtl/pulse_receiver_if.sv
// Pulse line in, measurement results out.
// master = the receiver, slave = whoever consumes the results and drives the line.
interface pulse_receiver_if #(
  parameter int CNT_W  = 32,
  parameter int PCNT_W = 16
);

  logic              pulse_in;
  logic [CNT_W-1:0]  width_o;
  logic              width_valid;
  logic              width_ok;
  logic              err_short;
  logic              err_long;
  logic              busy;
  logic [PCNT_W-1:0] pulse_count;

  modport master (
    input  pulse_in,
    output width_o, width_valid, width_ok, err_short, err_long, busy, pulse_count
  );

  modport slave (
    output pulse_in,
    input  width_o, width_valid, width_ok, err_short, err_long, busy, pulse_count
  );

endinterface

// File: rtl/pulse_receiver_sync_edge.sv
// Two-flop synchroniser for an asynchronous line plus one delay flop
// for edge detection on the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s2Dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s2Dly_q <= 1'b0;
    end else begin
      s1_q    <= async_i;
      s2_q    <= s1_q;
      s2Dly_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s2Dly_q;
  assign fall_o  = ~s2_q & s2Dly_q;

endmodule

// File: rtl/pulse_receiver.sv
// Measures the high time of each pulse on an asynchronous line, classifies it
// against [MIN_WIDTH, MAX_WIDTH] and counts the accepted ones.
module pulse_receiver
  import pulse_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MIN_WIDTH = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int PCNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  pulse_receiver_if.master  bus
);

  localparam logic [CNT_W-1:0] MinW = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MaxW = CNT_W'(MAX_WIDTH);

  logic level;
  logic rise;
  logic fall;

  sync_edge uSync (
    .clk     (clk),
    .reset   (reset),
    .async_i (bus.pulse_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [CNT_W-1:0]  width_q,   width_d;
  logic              wValid_q,  wValid_d;
  logic              ok_q,      ok_d;
  logic              short_q,   short_d;
  logic              errLong_q, errLong_d;
  logic [PCNT_W-1:0] pCount_q,  pCount_d;
  logic [1:0]        armFill_q, armFill_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARM;
      cnt_q     <= '0;
      width_q   <= '0;
      wValid_q  <= 1'b0;
      ok_q      <= 1'b0;
      short_q   <= 1'b0;
      errLong_q <= 1'b0;
      pCount_q  <= '0;
      armFill_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      wValid_q  <= wValid_d;
      ok_q      <= ok_d;
      short_q   <= short_d;
      errLong_q <= errLong_d;
      pCount_q  <= pCount_d;
      armFill_q <= armFill_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    wValid_d  = 1'b0;
    ok_d      = ok_q;
    short_d   = short_q;
    errLong_d = 1'b0;
    pCount_d  = pCount_q;
    armFill_d = armFill_q;

    case (state_q)
      // The synchroniser holds reset zeros for two edges, so trust the
      // level only once it carries a real sample of the line.
      ARM: begin
        if (armFill_q != 2'd2) begin
          armFill_d = armFill_q + 2'd1;
        end else if (!level) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (rise) begin
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (level) begin
          if (cnt_q == MaxW) begin
            errLong_d = 1'b1;
            cnt_d     = MaxW + 1'b1;
            state_d   = OVER;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (fall) begin
          width_d  = cnt_q;
          wValid_d = 1'b1;
          ok_d     = (cnt_q >= MinW);
          short_d  = (cnt_q < MinW);
          if (cnt_q >= MinW) begin
            pCount_d = pCount_q + 1'b1;
          end
          state_d = IDLE;
        end
      end

      OVER: begin
        if (!level) begin
          state_d = IDLE;
        end
      end

      default: state_d = ARM;
    endcase
  end

  assign bus.width_o     = width_q;
  assign bus.width_valid = wValid_q;
  assign bus.width_ok    = ok_q;
  assign bus.err_short   = short_q;
  assign bus.err_long    = errLong_q;
  assign bus.busy        = (state_q == HIGH) || (state_q == OVER);
  assign bus.pulse_count = pCount_q;

endmodule

// File: doc/pulse_receiver.md
Name: pulse_receiver

Overview:
- Receiving end of the single-shot square-pulse interface driven by the key-triggered pulse generator (nominal 50000 clk high, 1 ms at 50 MHz).
- Synchronises an asynchronous pulse line, measures each high period in clk cycles, classifies it against a window, and reports a one-cycle result strobe.
- Keeps a running count of accepted pulses.
- Sits on the consumer board/FPGA side; it can also loop back on the generator's output for self-test.

Parameters:
- CNT_W, 32, width of the width counter and width_o.
- MIN_WIDTH, 40000, shortest accepted high period in clk cycles (inclusive).
- MAX_WIDTH, 60000, longest accepted high period in clk cycles (inclusive); must satisfy MIN_WIDTH <= MAX_WIDTH < 2^CNT_W-1.
- PCNT_W, 16, width of pulse_count.

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- reset  in  1  asynchronous, active-high reset.
- pulse_in  in  1  asynchronous pulse line, active high.
- width_o  out  CNT_W  measured high width of the last completed in-window or short pulse.
- width_valid  out  1  one-cycle strobe; width_o and the flags are valid this cycle.
- width_ok  out  1  with width_valid: MIN_WIDTH <= width_o <= MAX_WIDTH.
- err_short  out  1  with width_valid: width_o < MIN_WIDTH.
- err_long  out  1  one-cycle strobe: high period exceeded MAX_WIDTH; never coincides with width_valid.
- busy  out  1  high while in HIGH or OVER.
- pulse_count  out  PCNT_W  number of width_ok pulses, wraps modulo 2^PCNT_W.

Behaviour:
- Reset values: all outputs 0; sync flops 0; counter 0; FSM in ARM.
- Reset is asynchronous; deassertion takes effect on the next clk edge.
- Input path: 2-FF synchroniser s1→s2, then one delay flop s2_d.
  - rise = s2 & ~s2_d; fall = ~s2 & s2_d.
- ARM: wait until s2 == 0, then go to IDLE. This prevents a pulse already high at reset release from being measured.
- IDLE: on rise, load cnt = 1 and go to HIGH.
- HIGH:
  - While s2 == 1, cnt increments by 1 each cycle.
  - When cnt would become MAX_WIDTH+1: assert err_long for one cycle, hold cnt, go to OVER.
  - On fall (cnt <= MAX_WIDTH):
    - Register width_o = cnt.
    - Assert width_valid for one cycle.
    - Set width_ok or err_short (mutually exclusive).
    - If ok, increment pulse_count.
    - Go to IDLE.
- OVER: ignore input until fall, then go to IDLE. No width_valid is issued for that pulse.
- Measured width equals the number of clk edges at which s2 was high, i.e. the input high time quantised to clk (±1 cycle on asynchronous input).
- Latency:
  - width_valid rises on the 3rd clk edge after the first edge that samples pulse_in low.
  - err_long fires on the edge where the (MAX_WIDTH+1)th high cycle is counted.
- Flag persistence: width_ok, err_short and width_o hold their values until the next width_valid. width_valid and err_long are strobes.
- Boundaries:
  - Width == MIN_WIDTH or == MAX_WIDTH → ok.
  - 1-cycle pulse → width 1, err_short.
  - pulse_count wraps from 2^PCNT_W-1 to 0 silently.
  - A low gap of 1 synced cycle between pulses is enough: fall to IDLE, then the next rise is accepted.
- Reset mid-pulse: everything is cleared and the FSM returns to ARM, so the remainder of the current pulse is discarded. No strobe is issued.
- Counter arithmetic is unsigned CNT_W and never wraps, because it is held at MAX_WIDTH+1.

Decomposition:
- Shared package pulse_pkg:
  - State enum {ARM, IDLE, HIGH, OVER}.
  - Constants CLK_HZ = 50_000_000 and NOM_WIDTH = 50000; the generator uses the same NOM_WIDTH.
  - Default MIN/MAX derived as NOM ±20%.
- Sub-module sync_edge: 2-FF synchroniser plus delay flop, outputs level, rise and fall.
- The FSM, counter and classification stay in pulse_receiver.

Test Plan:
- Reset with pulse_in=1, release, hold high 1000 cycles, drop → no width_valid, FSM stays in ARM until low; pulse_count=0.
- 50000-cycle pulse → width_valid once, 3 edges after the first low sample; width_o=50000, width_ok=1, pulse_count=1.
- Pulses of 40000 and 60000 cycles → both width_ok; 39999 → err_short, width_o=39999, count unchanged.
- 60001-cycle pulse → err_long strobe at the 60001st high cycle, no width_valid, busy until fall, then a 50000 pulse is accepted normally.
- Assert reset at cycle 20000 of a 50000 pulse → outputs 0 immediately, the rest of that pulse is ignored, the next pulse measures correctly.
- Preload pulse_count to 16'hFFFF via 65535 ok pulses (or force) → next ok pulse wraps it to 0.
